// File: rtl/axi_lib_pkg.sv
// Shared AXI4 burst/response constants, slave-write FSM encoding and burst context.
// The WRAP length check exists only when AXI4_SLAVE_WRITE_WRAP_EN is defined.
package axi_lib_pkg;

  localparam logic [1:0] AXI4_BURST_FIXED    = 2'b00;
  localparam logic [1:0] AXI4_BURST_INCR     = 2'b01;
  localparam logic [1:0] AXI4_BURST_WRAP     = 2'b10;
  localparam logic [1:0] AXI4_BURST_RESERVED = 2'b11;

  localparam logic [1:0] AXI4_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI4_RESP_SLVERR = 2'b10;

  // Context fields are sized for the widest supported ID/address; users cast down.
  localparam int AXI4_MAX_ID_W   = 16;
  localparam int AXI4_MAX_ADDR_W = 64;

  typedef enum logic [1:0] {
    ST_AXI_SLAVE_WRITE_IDLE,
    ST_AXI_SLAVE_WRITE_DATA,
    ST_AXI_SLAVE_WRITE_RESP
  } st_axi4_slave_write_t;

  typedef struct packed {
    logic [AXI4_MAX_ID_W-1:0]   id;
    logic [AXI4_MAX_ADDR_W-1:0] addr;
    logic [7:0]                 len;
    logic [1:0]                 burst;
    logic                       err;
  } axi4_slave_burst_ctx_t;

`ifdef AXI4_SLAVE_WRITE_WRAP_EN
  function automatic logic axi4_wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction
`endif

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Combinational next-beat address for FIXED/INCR bursts, plus WRAP under AXI4_SLAVE_WRITE_WRAP_EN.
// Zero latency, no handshake; INCR rolls over modulo 2^ADDR_WIDTH with no 4 KB check.
module axi4_burst_addr_gen
  import axi_lib_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  localparam int                    BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(DATA_WIDTH / 8);

  logic [ADDR_WIDTH-1:0] incr_addr;
  assign incr_addr = addr + STEP;

`ifdef AXI4_SLAVE_WRITE_WRAP_EN
  // Wrap window is (len+1) beats; the high bits stay on the window base.
  logic [ADDR_WIDTH-1:0] wrap_mask;
  assign wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << BYTE_SHIFT) - ADDR_WIDTH'(1);
`else
  logic len_unused;
  assign len_unused = ^len;
`endif

  always_comb begin
    next_addr = addr;
    case (burst)
      AXI4_BURST_FIXED: next_addr = addr;
      AXI4_BURST_INCR:  next_addr = incr_addr;
`ifdef AXI4_SLAVE_WRITE_WRAP_EN
      AXI4_BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
`endif
      default:          next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi4_slave_write.sv
// AXI4 write slave, one burst at a time, onto a simple mem_* write port; WRAP needs AXI4_SLAVE_WRITE_WRAP_EN.
// Each beat reaches mem_* one cycle after its handshake; B is held until bready, AW waits meanwhile.
module axi4_slave_write
  import axi_lib_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be
);

  localparam int LSB = $clog2(DATA_WIDTH / 8);

  st_axi4_slave_write_t  state;
  axi4_slave_burst_ctx_t ctx;
  logic [7:0]            beat_cnt;

  logic [ADDR_WIDTH-1:0] aligned_awaddr;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  last_beat;
  logic                  burst_bad;
  logic                  ctx_unused;

  assign aligned_awaddr = {awaddr[ADDR_WIDTH-1:LSB], {LSB{1'b0}}};
  assign cur_addr       = ADDR_WIDTH'(ctx.addr);
  assign last_beat      = (beat_cnt == ctx.len);
  assign ctx_unused     = ^{ctx.id, ctx.addr};

  // Unsupported bursts still consume every beat but never touch memory.
`ifdef AXI4_SLAVE_WRITE_WRAP_EN
  assign burst_bad = (awburst == AXI4_BURST_RESERVED) ||
                     ((awburst == AXI4_BURST_WRAP) && !axi4_wrap_len_ok(awlen));
`else
  assign burst_bad = (awburst == AXI4_BURST_RESERVED) || (awburst == AXI4_BURST_WRAP);
`endif

  axi4_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_addr_gen (
    .addr      (cur_addr),
    .len       (ctx.len),
    .burst     (ctx.burst),
    .next_addr (next_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_AXI_SLAVE_WRITE_IDLE;
      ctx       <= '0;
      beat_cnt  <= '0;
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bid       <= '0;
      bresp     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        ST_AXI_SLAVE_WRITE_IDLE: begin
          awready <= 1'b1;
          if (awvalid && awready) begin
            ctx.id    <= AXI4_MAX_ID_W'(awid);
            ctx.addr  <= AXI4_MAX_ADDR_W'(aligned_awaddr);
            ctx.len   <= awlen;
            ctx.burst <= awburst;
            ctx.err   <= burst_bad;
            beat_cnt  <= '0;
            awready   <= 1'b0;
            wready    <= 1'b1;
            state     <= ST_AXI_SLAVE_WRITE_DATA;
          end
        end
        ST_AXI_SLAVE_WRITE_DATA: begin
          if (wvalid && wready) begin
            mem_we    <= !ctx.err;
            mem_addr  <= cur_addr;
            mem_wdata <= wdata;
            mem_be    <= wstrb;
            ctx.addr  <= AXI4_MAX_ADDR_W'(next_addr);
            beat_cnt  <= beat_cnt + 8'd1;
            // Either end marker closes the burst; disagreement between them is a protocol error.
            if (wlast || last_beat) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              bid    <= ID_WIDTH'(ctx.id);
              bresp  <= (ctx.err || (wlast != last_beat)) ? AXI4_RESP_SLVERR : AXI4_RESP_OKAY;
              state  <= ST_AXI_SLAVE_WRITE_RESP;
            end
          end
        end
        ST_AXI_SLAVE_WRITE_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            state   <= ST_AXI_SLAVE_WRITE_IDLE;
          end
        end
        default: state <= ST_AXI_SLAVE_WRITE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_slave_write.sv
// Randomized scoreboard bench for axi4_slave_write; expectations follow AXI4_SLAVE_WRITE_WRAP_EN.
module tb_axi4_slave_write;

  localparam int IW = 4;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [IW-1:0] awid = '0;
  logic [AW-1:0] awaddr = '0;
  logic [7:0]    awlen = '0;
  logic [1:0]    awburst = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [DW-1:0] wdata = '0;
  logic [SW-1:0] wstrb = '0;
  logic          wlast = 1'b0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [IW-1:0] bid;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_be;

  always #5 clk = ~clk;

  axi4_slave_write #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be)
  );

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic [SW-1:0] be; } wr_t;
  typedef struct { logic [IW-1:0] id; logic [1:0] resp; } b_t;

  wr_t exp_w[$];
  b_t  exp_b[$];
  wr_t mon_w;
  b_t  mon_b;
  int  n_cmp = 0;
  int  n_bad = 0;
  logic prev_beat = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: outputs and inputs are both stable at the falling edge.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      check("mem_we_one_cycle_after_beat", 64'(prev_beat), 64'd1);
      if (exp_w.size() == 0) begin
        fail_now($sformatf("unexpected_write addr=%0h data=%0h", mem_addr, mem_wdata));
      end else begin
        mon_w = exp_w.pop_front();
        check("mem_addr", 64'(mem_addr), 64'(mon_w.addr));
        check("mem_wdata", 64'(mem_wdata), 64'(mon_w.data));
        check("mem_be", 64'(mem_be), 64'(mon_w.be));
      end
    end
    if (bvalid === 1'b1 && bready) begin
      if (exp_b.size() == 0) begin
        fail_now($sformatf("unexpected_b bid=%0h bresp=%0h", bid, bresp));
      end else begin
        mon_b = exp_b.pop_front();
        check("bid", 64'(bid), 64'(mon_b.id));
        check("bresp", 64'(bresp), 64'(mon_b.resp));
      end
    end
    prev_beat = wvalid && (wready === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("reset_outputs_zero",
          64'(|{awready, wready, bvalid, bid, bresp, mem_we, mem_addr, mem_wdata, mem_be}), 64'd0);
    tick();
    tick();
    check("reset_held_outputs_zero",
          64'(|{awready, wready, bvalid, bid, bresp, mem_we, mem_addr, mem_wdata, mem_be}), 64'd0);
    rst = 1'b0;
    #1;
    check("awready_low_before_first_edge", 64'(awready), 64'd0);
    tick();
    check("awready_after_reset_release", 64'(awready), 64'd1);
  endtask

  task automatic aw_send(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int t;
    t = 0;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    while (awready !== 1'b1 && t < 200) begin tick(); t++; end
    if (t >= 200) fail_now("aw_handshake_timeout");
    tick();
    awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [DW-1:0] d, input logic [SW-1:0] s, input bit last, input bit gap);
    int t;
    t = 0;
    if (gap) begin wvalid = 1'b0; tick(); end
    wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
    while (wready !== 1'b1 && t < 200) begin tick(); t++; end
    if (t >= 200) fail_now("w_handshake_timeout");
    tick();
    wvalid = 1'b0;
    wlast = 1'b0;
  endtask

  task automatic b_take(input int delay, input bit stall_chk, input logic [IW-1:0] eid, input logic [1:0] eresp);
    int t;
    t = 0;
    bready = 1'b0;
    for (int k = 0; k < delay; k++) begin
      if (stall_chk) begin
        check("stall_bvalid", 64'(bvalid), 64'd1);
        check("stall_bid", 64'(bid), 64'(eid));
        check("stall_bresp", 64'(bresp), 64'(eresp));
        check("stall_awready", 64'(awready), 64'd0);
      end
      tick();
    end
    bready = 1'b1;
    while (bvalid !== 1'b1 && t < 200) begin tick(); t++; end
    if (t >= 200) fail_now("b_handshake_timeout");
    tick();
    bready = 1'b0;
  endtask

  // gap_mode: 0 = back-to-back beats, 1 = idle cycle before every beat, 2 = random idles.
  task automatic run_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int early, input bit drop_last,
                           input int gap_mode, input int bdelay, input bit stall_chk);
    logic [DW-1:0] d[$];
    logic [SW-1:0] s[$];
    bit            l[$];
    int  n, start, size, base, a;
    bit  wrap_ok, supported, err;
    logic [1:0] resp;

    n = (early >= 0) ? early + 1 : int'(len) + 1;
    for (int i = 0; i < n; i++) begin
      d.push_back($urandom);
      s.push_back(SW'($urandom));
      l.push_back((early >= 0) ? (i == early) : (i == int'(len) && !drop_last));
    end

`ifdef AXI4_SLAVE_WRITE_WRAP_EN
    wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
`else
    wrap_ok = 1'b0;
`endif
    supported = (burst == 2'b00) || (burst == 2'b01) || (burst == 2'b10 && wrap_ok);
    err  = !supported || (n != int'(len) + 1) || !l[n-1];
    resp = err ? 2'b10 : 2'b00;

    start = int'(addr) & ~(SW - 1);
    size  = (int'(len) + 1) * SW;
    base  = (start / size) * size;
    if (supported) begin
      for (int i = 0; i < n; i++) begin
        if (burst == 2'b00)      a = start;
        else if (burst == 2'b01) a = (start + SW * i) % (1 << AW);
        else                     a = base + (start - base + SW * i) % size;
        exp_w.push_back('{AW'(a), d[i], s[i]});
      end
    end
    exp_b.push_back('{id, resp});

    aw_send(id, addr, len, burst);
    for (int i = 0; i < n; i++)
      w_send(d[i], s[i], l[i], (gap_mode == 1) || (gap_mode == 2 && $urandom_range(0, 1) == 1));
    b_take(bdelay, stall_chk, id, resp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  early;
    bit  drop;
    logic [1:0] bt;
    logic [7:0] ln;

    #1;
    do_reset();

    // Single beat from an unaligned address.
    exp_w.push_back('{12'h010, 32'hDEADBEEF, 4'hF});
    exp_b.push_back('{4'h9, 2'b00});
    aw_send(4'h9, 12'h013, 8'd0, 2'b01);
    w_send(32'hDEADBEEF, 4'hF, 1'b1, 1'b0);
    b_take(0, 1'b0, 4'h9, 2'b00);

    run_burst(4'h3, 12'h100, 8'd3, 2'b01, -1, 1'b0, 1, 0, 1'b0); // INCR, wvalid every other cycle
    run_burst(4'h4, 12'h040, 8'd3, 2'b01, 1, 1'b0, 0, 1, 1'b0);  // wlast on beat 2
    run_burst(4'h5, 12'h080, 8'd3, 2'b01, -1, 1'b1, 0, 0, 1'b0); // wlast missing on beat 4
    run_burst(4'h6, 12'h038, 8'd3, 2'b10, -1, 1'b0, 0, 0, 1'b0); // WRAP
    run_burst(4'h7, 12'h204, 8'd2, 2'b00, -1, 1'b0, 0, 0, 1'b0); // FIXED
    run_burst(4'h8, 12'h300, 8'd1, 2'b11, -1, 1'b0, 0, 0, 1'b0); // reserved
    run_burst(4'hA, 12'hFF8, 8'd3, 2'b01, -1, 1'b0, 2, 0, 1'b0); // INCR address rollover
    run_burst(4'hB, 12'h400, 8'd0, 2'b01, -1, 1'b0, 0, 10, 1'b1); // bready low 10 cycles

    // Reset in the middle of an 8-beat burst: only the two accepted beats may appear.
    exp_w.push_back('{12'h200, 32'h11111111, 4'hF});
    exp_w.push_back('{12'h204, 32'h22222222, 4'h3});
    aw_send(4'hC, 12'h200, 8'd7, 2'b01);
    w_send(32'h11111111, 4'hF, 1'b0, 1'b0);
    w_send(32'h22222222, 4'h3, 1'b0, 1'b0);
    tick();
    check("pre_reset_writes_seen", 64'(exp_w.size()), 64'd0);
    do_reset();
    for (int k = 0; k < 6; k++) begin
      check("post_reset_no_mem_we", 64'(mem_we), 64'd0);
      check("post_reset_no_bvalid", 64'(bvalid), 64'd0);
      tick();
    end

    for (int r = 0; r < 40; r++) begin
      bt = 2'($urandom_range(0, 3));
      ln = (bt == 2'b10 && $urandom_range(0, 3) != 0) ? 8'((1 << $urandom_range(1, 4)) - 1)
                                                      : 8'($urandom_range(0, 15));
      early = -1;
      drop  = 1'b0;
      if ($urandom_range(0, 7) == 0 && ln > 0) early = $urandom_range(0, int'(ln) - 1);
      else if ($urandom_range(0, 7) == 0) drop = 1'b1;
      run_burst(IW'($urandom), AW'($urandom), ln, bt, early, drop, 2, $urandom_range(0, 3), 1'b0);
    end

    repeat (5) tick();
    check("exp_w_drained", 64'(exp_w.size()), 64'd0);
    check("exp_b_drained", 64'(exp_b.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi4_slave_write.md
AXI4_SLAVE_WRITE -- requirements
Module: axi4_slave_write

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4: width of awid/bid.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12: byte address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: data width, power of two, at least 32.
REQ-004 SHALL have clk  input  1  single clock; every register is clocked on its rising edge.
REQ-005 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have awid  input  ID_WIDTH  write transaction ID.
REQ-007 SHALL have awaddr  input  ADDR_WIDTH  burst start byte address.
REQ-008 SHALL have awlen  input  8  beats minus one.
REQ-009 SHALL have awburst  input  2  burst type.
REQ-010 SHALL have awvalid / awready  input / output  1 / 1  address-write handshake.
REQ-011 SHALL have wdata  input  DATA_WIDTH  beat data.
REQ-012 SHALL have wstrb  input  DATA_WIDTH/8  byte strobes.
REQ-013 SHALL have wlast  input  1  master's last-beat marker.
REQ-014 SHALL have wvalid / wready  input / output  1 / 1  write-data handshake.
REQ-015 SHALL have bid  output  ID_WIDTH  response ID.
REQ-016 SHALL have bresp  output  2  write response.
REQ-017 SHALL have bvalid / bready  output / input  1 / 1  response handshake.
REQ-018 SHALL have mem_we  output  1  one-cycle memory write pulse.
REQ-019 SHALL have mem_addr  output  ADDR_WIDTH  memory byte address, beat-aligned.
REQ-020 SHALL have mem_wdata / mem_be  output  DATA_WIDTH / DATA_WIDTH/8  write data and byte enables.

Function
REQ-021 SHALL use a three-state FSM:
- IDLE: awready=1.
- DATA: wready=1.
- RESP: bvalid=1.
- All other handshake outputs are 0 in each state.
REQ-022 SHALL, in IDLE, on awvalid&awready capture the following and go to DATA:
- awid;
- awaddr aligned down to DATA_WIDTH/8;
- awlen;
- awburst.
REQ-023 SHALL treat all beats as full-width; awsize is not supported, and the master must drive log2(DATA_WIDTH/8).
REQ-024 SHALL register each wvalid&wready beat onto the mem_* port with exactly one cycle of latency: mem_we=1 for one cycle, mem_be=wstrb (including all-zero strobes).
REQ-025 SHALL compute the next beat address as follows:
- INCR: current address plus DATA_WIDTH/8, modulo 2^ADDR_WIDTH; no 4 KB check.
- FIXED: the address is held.
REQ-026 SHALL end the data phase after awlen+1 beats and go to RESP in the cycle after the final beat handshake.
REQ-027 SHALL handle wlast protocol errors as follows:
- wlast=1 before beat awlen+1: that beat is written, the burst ends, and bresp=SLVERR.
- wlast=0 on beat awlen+1: the burst still ends, and bresp=SLVERR.
REQ-028 SHALL handle burst type 2'b11 (reserved), and WRAP when the macro is absent, as follows: all awlen+1 beats are accepted, mem_we stays 0, and bresp=SLVERR.
REQ-029 SHALL otherwise return bresp=OKAY, and bid SHALL equal the captured awid.
REQ-030 SHALL hold bvalid, bid and bresp stable until bready; on bvalid&bready go to IDLE, and awready SHALL be 1 in the following cycle.
REQ-031 SHALL accept only one burst at a time; awvalid arriving in DATA or RESP waits.

Reset
REQ-032 SHALL, while rst=1, force the FSM to IDLE and drive every output to 0, including awready; awready SHALL rise on the first clk edge after rst falls.
REQ-033 SHALL, on reset during DATA or RESP, discard the burst: no further mem_we and no B response.

Configuration
REQ-034 SHALL support WRAP bursts when the macro AXI4_SLAVE_WRITE_WRAP_EN is defined, with the following rules:
- awlen must be 1, 3, 7 or 15, else the burst is handled as in REQ-028;
- the wrap boundary is (awlen+1)*DATA_WIDTH/8 bytes;
- the address wraps to the aligned boundary base.
REQ-035 SHALL, without AXI4_SLAVE_WRITE_WRAP_EN, contain no wrap logic, and WRAP is handled per REQ-028.

Structure
REQ-036 SHALL place the following in axi_lib_pkg:
- the FSM enum st_axi4_slave_write_t (ST_AXI_SLAVE_WRITE_IDLE/DATA/RESP);
- a packed struct axi4_slave_burst_ctx_t holding id, addr, len, burst and error flag;
- use of the existing AXI4_BURST_* and AXI4_RESP_* constants, with no literals.
REQ-037 SHALL factor next-address computation (FIXED/INCR/WRAP) into the sub-module axi4_burst_addr_gen.

Verification
REQ-038 SHALL cover single beat: awaddr=0x013, awlen=0, INCR, wdata=0xDEADBEEF, wstrb=0xF, wlast=1 -> mem_addr=0x010, mem_we one cycle after the beat, bresp=OKAY, bid=awid.
REQ-039 SHALL cover INCR burst: awaddr=0x100, awlen=3, wvalid toggling every other cycle -> mem_addr 0x100, 0x104, 0x108, 0x10C; one B with OKAY.
REQ-040 SHALL cover early wlast: awlen=3, wlast on beat 2 -> 2 writes, RESP, bresp=SLVERR; missing wlast on beat 4 -> 4 writes, SLVERR.
REQ-041 SHALL cover WRAP: awaddr=0x038, awlen=3 -> 0x038, 0x03C, 0x030, 0x034 with the macro; without it -> 0 writes and SLVERR.
REQ-042 SHALL cover backpressure/reset:
- bready held low 10 cycles -> bvalid/bid/bresp stable and awready=0;
- rst pulsed mid-burst -> no mem_we and no bvalid afterwards, and awready=1 one cycle after release.
